uart_rx_os: RTL and testbench
=============================

// Module: uart_rx_os
// PURPOSE
//  Parametrised oversampling UART receiver: mid-bit sampling, configurable frame
//  format, valid/ready output handshake, per-frame error flags. Sits between the
//  board RXD pin and the byte consumer (LED/register logic). One i_clk domain;
//  baud timing comes from the baud generator as a one-cycle i_tick enable.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, 5..9, LSB first
//  OVERSAMPLE  16  i_tick pulses per bit period, even, >=4
//  PARITY_EN   0   1 = parity bit follows data
//  PARITY_ODD  0   1 = odd parity, 0 = even (ignored if PARITY_EN=0)
//  STOP_BITS   1   stop bits checked, 1 or 2
// PORTS
//  i_clk         in   1          system clock
//  i_reset       in   1          asynchronous, active-high reset
//  i_tick        in   1          oversample enable, 1 i_clk wide
//  i_rxd         in   1          serial input, idle high, asynchronous
//  o_data        out  DATA_BITS  received word
//  o_valid       out  1          o_data/error flags valid
//  i_ready       in   1          consumer accepts word when o_valid&i_ready
//  o_frame_err   out  1          a stop bit of this word sampled low
//  o_parity_err  out  1          parity mismatch on this word
//  o_overrun     out  1          1-cycle pulse: frame dropped, o_valid was still high
//  o_busy        out  1          high in any state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, counters 0, 2-flop i_rxd synchroniser = 1.
//  - All sampling uses synchronised rxd (rxs); FSM/counters advance only on i_tick.
//  - IDLE: start on falling edge of rxs (previous tick-sample 1, current 0);
//    stuck-low line never retriggers. -> START, tick count cleared.
//  - START: after OVERSAMPLE/2 ticks sample rxs; 0 -> DATA; 1 -> IDLE (glitch,
//    nothing reported).
//  - DATA: every OVERSAMPLE ticks sample one bit into shift reg, LSB first;
//    after DATA_BITS samples -> PARITY if PARITY_EN else STOP.
//  - PARITY: sample after OVERSAMPLE ticks; perr = (^data ^ bit) != PARITY_ODD.
//  - STOP: STOP_BITS samples, OVERSAMPLE ticks apart; any 0 -> ferr.
//    After last stop sample -> IDLE (mid-stop; next start edge accepted at once).
//  - Completion: on the i_clk after the final stop sample tick:
//    if !o_valid or (o_valid&i_ready) same cycle: load o_data, o_frame_err,
//    o_parity_err; o_valid<=1. Else: o_overrun=1 for 1 cycle, new frame dropped,
//    held word/flags unchanged.
//  - Handshake: o_valid, o_data, flags stable until o_valid&i_ready; then
//    o_valid<=0 next cycle (flags hold last value, meaningful only with o_valid).
//  - Framing-error words are still delivered (with o_frame_err=1).
//  - Tick counter width $clog2(OVERSAMPLE), bit counter $clog2(DATA_BITS+1);
//    both clear on every state change; no wrap beyond terminal count.
//  - i_reset mid-frame: immediate abort to reset values; partial frame lost.
//  - Latency: o_valid rises 1 i_clk after the tick of the final stop sample.
// TESTING (OVERSAMPLE=16, i_tick every 4 clk, i_ready=1 unless stated)
//  1. 8N1 send 0xA5 -> o_valid 1 cycle, o_data=0xA5, flags 0, o_busy low after.
//  2. i_rxd low 5 ticks then high -> no o_valid, FSM back to IDLE, o_busy pulse.
//  3. 0x3C with stop bit=0 -> o_data=0x3C, o_frame_err=1, o_valid=1.
//  4. PARITY_EN=1 even: 0x07 with parity 0 -> o_parity_err=1; parity 1 -> 0.
//  5. i_ready=0, send 0x11 then 0x22 -> o_data=0x11 held, o_overrun 1-cycle pulse.
//  6. i_reset high mid DATA of 0xFF -> all outputs 0; next 0x5A received clean.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling on i_tick, configurable frame
// format, valid/ready output slot with per-word framing/parity flags.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          P_ODD     = (PARITY_ODD != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic                 r_meta;
  logic                 r_rxs;
  logic                 r_rxs_prev;
  state_t               r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;

  logic w_done;
  logic w_slot_free;

  // NOTE: the synchroniser resets to the idle level so reset release never looks like a start edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_meta <= 1'b1;
      r_rxs  <= 1'b1;
    end else begin
      r_meta <= i_rxd;
      r_rxs  <= r_meta;
    end
  end

  assign w_done      = i_tick && (r_state == S_STOP) && (r_tick_cnt == FULL_M1)
                       && (r_bit_cnt == LAST_STOP);
  assign w_slot_free = !o_valid || i_ready;

  // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rxs_prev   <= 1'b1;
      r_state      <= S_IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;

      // A finished frame either takes the output slot or is dropped with a pulse.
      if (w_done) begin
        if (w_slot_free) begin
          o_data       <= r_shift;
          o_frame_err  <= r_ferr | ~r_rxs;
          o_parity_err <= r_perr;
          o_valid      <= 1'b1;
        end else begin
          o_overrun    <= 1'b1;
        end
      end

      if (i_tick) begin
        r_rxs_prev <= r_rxs;
        case (r_state)
          S_IDLE: begin
            if (r_rxs_prev && !r_rxs) begin
              r_state    <= S_START;
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_perr     <= 1'b0;
              r_ferr     <= 1'b0;
              o_busy     <= 1'b1;
            end
          end
          S_START: begin
            if (r_tick_cnt == HALF_M1) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              if (!r_rxs) begin
                r_state <= S_DATA;
              end else begin
                r_state <= S_IDLE;
                o_busy  <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (r_tick_cnt == FULL_M1) begin
              r_tick_cnt <= '0;
              r_shift    <= {r_rxs, r_shift[DATA_BITS-1:1]};
              if (r_bit_cnt == LAST_DATA) begin
                r_bit_cnt <= '0;
                r_state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          S_PARITY: begin
            if (r_tick_cnt == FULL_M1) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_perr     <= ((^r_shift) ^ r_rxs) != P_ODD;
              r_state    <= S_STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (r_tick_cnt == FULL_M1) begin
              r_tick_cnt <= '0;
              if (!r_rxs) r_ferr <= 1'b1;
              if (r_bit_cnt == LAST_STOP) begin
                r_bit_cnt <= '0;
                r_state   <= S_IDLE;
                o_busy    <= 1'b0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 instance and an 8E2 instance driven with directed
// and random frames; expected words come from the bits the bench itself sends.
module tb_uart_rx_os;

  localparam int OS     = 16;
  localparam int BITCLK = OS * 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rxd0 = 1'b1, rxd1 = 1'b1;
  logic       ready0 = 1'b1, ready1 = 1'b1;
  logic [7:0] data0, data1;
  logic       valid0, valid1, ferr0, ferr1, perr0, perr1, ovr0, ovr1, busy0, busy1;

  always #5 clk = ~clk;

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_rxd(rxd0),
    .o_data(data0), .o_valid(valid0), .i_ready(ready0),
    .o_frame_err(ferr0), .o_parity_err(perr0), .o_overrun(ovr0), .o_busy(busy0));

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_rxd(rxd1),
    .o_data(data1), .o_valid(valid1), .i_ready(ready1),
    .o_frame_err(ferr1), .o_parity_err(perr1), .o_overrun(ovr1), .o_busy(busy1));

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t       q0[$], q1[$];
  int         drop[2];
  int         vhigh[2];
  logic [7:0] pd[2];
  logic       pv[2], pr[2], po[2];
  bit         busy_seen0 = 0;
  bit         rnd = 0;
  int         checks = 0, passes = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_clks(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c = 0;
    forever begin
      @(posedge clk); #1;
      tick = (c == 3);
      c = (c + 1) % 4;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd) begin
        ready0 = 1'($urandom_range(0, 1));
        ready1 = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic set_rxd(int d, logic v);
    if (d == 0) rxd0 = v;
    else rxd1 = v;
  endtask

  // d=0: 8N1, d=1: 8E2. flip inverts the correct parity bit. abort_after>=0
  // stops driving after that many bits (no word expected). expect_drop means
  // the frame must be discarded with an overrun pulse.
  task automatic send_frame(int d, logic [7:0] data, logic flip, logic stop_a,
                            logic stop_b, int abort_after, bit expect_drop);
    logic bits[$];
    logic pbit;
    exp_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    pbit = (^data) ^ flip;
    if (d == 1) bits.push_back(pbit);
    bits.push_back(stop_a);
    if (d == 1) bits.push_back(stop_b);
    e.data = data;
    e.ferr = !stop_a || (d == 1 && !stop_b);
    e.perr = (d == 1) && (pbit != (^data));
    if (abort_after < 0) begin
      if (expect_drop) drop[d]++;
      else if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    for (int i = 0; i < bits.size(); i++) begin
      if (abort_after >= 0 && i == abort_after) begin
        set_rxd(d, 1'b1);
        return;
      end
      set_rxd(d, bits[i]);
      wait_clks(BITCLK);
    end
    set_rxd(d, 1'b1);
    if (e.ferr) wait_clks(BITCLK);
  endtask

  task automatic mon(int d, logic [7:0] data, logic v, logic fe, logic pe, logic ov, logic rdy);
    exp_t e;
    bit   have;
    if (pv[d] && !pr[d]) check($sformatf("hold%0d", d), {v, data}, {1'b1, pd[d]});
    if (v) vhigh[d]++;
    if (v && rdy) begin
      have = 0;
      if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
      if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
      if (have) begin
        check($sformatf("word%0d", d), {data, fe, pe}, {e.data, e.ferr, e.perr});
      end else begin
        checks++;
        $display("FAIL unexpected_valid%0d: got word 0x%0h, expected none", d, data);
      end
    end
    if (ov) begin
      check($sformatf("overrun_width%0d", d), po[d], 0);
      checks++;
      if (drop[d] > 0 && v) begin
        passes++;
        drop[d]--;
      end else begin
        $display("FAIL overrun%0d: got pulse with valid=%0b, expected drops=%0d", d, v, drop[d]);
      end
    end
    pv[d] = v; pr[d] = rdy; pd[d] = data; po[d] = ov;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin pv[i] = 0; pr[i] = 0; po[i] = 0; end
    end else begin
      mon(0, data0, valid0, ferr0, perr0, ovr0, ready0);
      mon(1, data1, valid1, ferr1, perr1, ovr1, ready1);
      if (busy0) busy_seen0 = 1;
    end
  end

  initial begin
    drop[0] = 0; drop[1] = 0; vhigh[0] = 0; vhigh[1] = 0;
    wait_clks(5);
    check("reset_out0", {data0, valid0, ferr0, perr0, ovr0, busy0}, 0);
    check("reset_out1", {data1, valid1, ferr1, perr1, ovr1, busy1}, 0);
    rst = 1'b0;
    wait_clks(3 * BITCLK);

    // 8N1 0xA5: one valid cycle, clean flags, idle afterwards
    vhigh[0] = 0;
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, -1, 0);
    wait_clks(BITCLK);
    check("t1_valid_cycles", vhigh[0], 1);
    check("t1_data", data0, 8'hA5);
    check("t1_flags", {ferr0, perr0}, 0);
    check("t1_busy", busy0, 0);

    // Start-bit glitch of 5 ticks
    busy_seen0 = 0; vhigh[0] = 0;
    rxd0 = 1'b0;
    wait_clks(5 * 4);
    rxd0 = 1'b1;
    wait_clks(2 * BITCLK);
    check("t2_busy_pulse", busy_seen0, 1);
    check("t2_busy_low", busy0, 0);
    check("t2_no_valid", vhigh[0], 0);

    // Framing error is still delivered
    vhigh[0] = 0;
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, -1, 0);
    check("t3_data", data0, 8'h3C);
    check("t3_ferr", ferr0, 1);
    check("t3_valid_cycles", vhigh[0], 1);

    // Even parity on the 8E2 instance
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, -1, 0);
    wait_clks(BITCLK);
    check("t4_perr_bad", {data1, perr1, ferr1}, {8'h07, 1'b1, 1'b0});
    send_frame(1, 8'h07, 1'b0, 1'b1, 1'b1, -1, 0);
    wait_clks(BITCLK);
    check("t4_perr_good", {data1, perr1, ferr1}, {8'h07, 1'b0, 1'b0});
    send_frame(1, 8'h81, 1'b0, 1'b1, 1'b0, -1, 0);
    check("t4_second_stop_ferr", {data1, perr1, ferr1}, {8'h81, 1'b0, 1'b1});

    // Overrun: consumer stalled across two frames
    ready0 = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1, -1, 0);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, -1, 1);
    wait_clks(BITCLK);
    check("t5_held", {valid0, data0}, {1'b1, 8'h11});
    check("t5_overrun_seen", drop[0], 0);
    ready0 = 1'b1;
    wait_clks(4);
    check("t5_released", {valid0, 32'(q0.size())}, 0);

    // Reset in the middle of the data bits of 0xFF
    send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b1, 5, 0);
    rst = 1'b1;
    wait_clks(3);
    check("t6_reset_out0", {data0, valid0, ferr0, perr0, ovr0, busy0}, 0);
    rst = 1'b0;
    wait_clks(2 * BITCLK);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1, -1, 0);
    wait_clks(BITCLK);
    check("t6_clean", {data0, ferr0, perr0, busy0}, {8'h5A, 3'b000});

    // Random frames on both instances with a randomly stalling consumer
    rnd = 1;
    fork
      for (int n = 0; n < 25; n++) begin
        send_frame(0, 8'($urandom), 1'b0, 1'($urandom_range(0, 3) != 0), 1'b1, -1, 0);
        wait_clks($urandom_range(0, 40));
      end
      for (int n = 0; n < 25; n++) begin
        send_frame(1, 8'($urandom), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0), -1, 0);
        wait_clks($urandom_range(0, 40));
      end
    join
    rnd = 0;
    ready0 = 1'b1;
    ready1 = 1'b1;
    wait_clks(2 * BITCLK);
    check("end_queue0", q0.size(), 0);
    check("end_queue1", q1.size(), 0);
    check("end_drops", drop[0] + drop[1], 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
